// File: rtl/ttl_7458_bist_pkg.sv
// Shared definitions for the 7458 self-test engine: FSM states,
// vector count and the field positions of p1/p2 inside a vector index.
package ttl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int N_VEC_7458 = 1024;

    localparam int P1_LSB = 0;
    localparam int P1_W   = 6;
    localparam int P2_LSB = 6;
    localparam int P2_W   = 4;

    localparam logic [9:0] LAST_VEC = 10'(N_VEC_7458 - 1);

endpackage

// File: rtl/ttl_7458_bist_if.sv
// Pin-level connection between the self-test engine and a 7458 instance.
// The engine is the master: it drives the gate inputs and reads back y.
interface ttl_7458_bist_if;

    logic [5:0] p1;
    logic [3:0] p2;
    logic       p1y;
    logic       p2y;

    modport master (
        output p1,
        output p2,
        input  p1y,
        input  p2y
    );

    modport slave (
        input  p1,
        input  p2,
        output p1y,
        output p2y
    );

endinterface

// File: rtl/ttl_7458_bist_model.sv
// Combinational golden model of the 7458 dual AND-OR gate.
// Kept standalone so other benches can reuse it as a reference.
module ttl_7458_model (
    input  logic [5:0] p1,
    input  logic [3:0] p2,
    output logic       exp_p1y,
    output logic       exp_p2y
);

    // 3-3 AND-OR on the first gate, 2-2 AND-OR on the second
    assign exp_p1y = (p1[0] & p1[1] & p1[2]) | (p1[3] & p1[4] & p1[5]);
    assign exp_p2y = (p2[0] & p2[1]) | (p2[2] & p2[3]);

endmodule

// File: rtl/ttl_7458_bist.sv
// Exhaustive self-test engine for a 7458: walks all 1024 input vectors,
// holds each for SETTLE_CYCLES, then compares the gate outputs against
// the golden model and accumulates an error count and first failure.
module ttl_7458_bist
    import ttl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    ttl_7458_bist_if.master  pins,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [10:0]      err_count,
    output logic             fail_valid,
    output logic [9:0]       first_fail
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [9:0] v;
    logic [7:0] settle_cnt;
    logic       exp_p1y;
    logic       exp_p2y;
    logic       mismatch;

    // Pins follow the vector register directly so they only move when v does
    assign pins.p1 = v[P1_LSB +: P1_W];
    assign pins.p2 = v[P2_LSB +: P2_W];

    ttl_7458_model u_model (
        .p1      (v[P1_LSB +: P1_W]),
        .p2      (v[P2_LSB +: P2_W]),
        .exp_p1y (exp_p1y),
        .exp_p2y (exp_p2y)
    );

    // One mismatch per vector regardless of how many outputs are wrong
    assign mismatch = (pins.p1y != exp_p1y) || (pins.p2y != exp_p2y);

    // Test sequencer: start/abort handling, settle timing, checking and results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            v          <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        state      <= SETTLE;
                        v          <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state      <= CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + 11'd1;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                first_fail <= v;
                            end
                        end
                        if (v == LAST_VEC) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= !fail_valid && !mismatch;
                        end else begin
                            state <= SETTLE;
                            v     <= v + 10'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ttl_7458_bist.sv
// Directed bench for the 7458 self-test engine. A behavioural 7458 with
// selectable faults sits on the pin interface; every run's results are
// compared against hand-computed counts.
module tb_ttl_7458_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_count;
    logic        fail_valid;
    logic [9:0]  first_fail;

    int          fault_mode;
    int          n_compared;
    int          n_mismatched;
    int          cyc;
    logic        saw_done;

    ttl_7458_bist_if bus ();

    ttl_7458_bist #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pins       (bus.master),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .first_fail (first_fail)
    );

    // Behavioural 7458: 0 good, 1 p1y stuck 0, 2 p2y stuck 0, 3 both inverted
    logic good_p1y;
    logic good_p2y;
    assign good_p1y = (bus.p1[0] & bus.p1[1] & bus.p1[2]) | (bus.p1[3] & bus.p1[4] & bus.p1[5]);
    assign good_p2y = (bus.p2[0] & bus.p2[1]) | (bus.p2[2] & bus.p2[3]);
    assign bus.p1y  = (fault_mode == 1) ? 1'b0 : (fault_mode == 3) ? ~good_p1y : good_p1y;
    assign bus.p2y  = (fault_mode == 2) ? 1'b0 : (fault_mode == 3) ? ~good_p2y : good_p2y;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, observed, observed, expected, expected);
        end
    endtask

    // Pulse start, then count edges until done; optional extra start while busy
    task automatic applyStimulus(input int fault, input int busy_start_at);
        fault_mode = fault;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        cyc = 0;
        while (!done && cyc < 5000) begin
            if (cyc == busy_start_at) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        checkOutput("run_cycles", cyc, 3072);
        checkOutput("done_high", done, 1);
        checkOutput("busy_low_at_done", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        fault_mode   = 0;
        start        = 1'b0;
        abort        = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_pass", pass, 0);
        checkOutput("rst_err", err_count, 0);
        checkOutput("rst_fv", fail_valid, 0);
        checkOutput("rst_ff", first_fail, 0);
        checkOutput("rst_p1", bus.p1, 0);
        checkOutput("rst_p2", bus.p2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] good device run");
        applyStimulus(0, -1);
        checkOutput("good_pass", pass, 1);
        checkOutput("good_err", err_count, 0);
        checkOutput("good_fv", fail_valid, 0);

        $display("[TB] p1y stuck at 0");
        applyStimulus(1, -1);
        checkOutput("p1y0_err", err_count, 240);
        checkOutput("p1y0_ff", first_fail, 10'h007);
        checkOutput("p1y0_fv", fail_valid, 1);
        checkOutput("p1y0_pass", pass, 0);

        $display("[TB] p2y stuck at 0");
        applyStimulus(2, -1);
        checkOutput("p2y0_err", err_count, 448);
        checkOutput("p2y0_ff", first_fail, 10'h0C0);
        checkOutput("p2y0_pass", pass, 0);

        $display("[TB] both outputs inverted");
        applyStimulus(3, -1);
        checkOutput("inv_err", err_count, 1024);
        checkOutput("inv_ff", first_fail, 0);
        checkOutput("inv_fv", fail_valid, 1);
        checkOutput("inv_pass", pass, 0);

        // Abort after 100 cycles: vectors 0..32 checked, mismatches at 7,15,23,31
        $display("[TB] abort mid-run");
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pass", pass, 0);
        checkOutput("abort_err", err_count, 4);
        checkOutput("abort_ff", first_fail, 10'h007);
        saw_done = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        checkOutput("abort_stays_idle", saw_done, 0);
        applyStimulus(0, -1);
        checkOutput("after_abort_pass", pass, 1);
        checkOutput("after_abort_err", err_count, 0);

        // Asynchronous reset mid-run, observed with no clock edge in between
        $display("[TB] reset mid-run");
        fault_mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_err", err_count, 0);
        checkOutput("arst_fv", fail_valid, 0);
        checkOutput("arst_ff", first_fail, 0);
        checkOutput("arst_p1", bus.p1, 0);
        checkOutput("arst_p2", bus.p2, 0);
        checkOutput("arst_pass", pass, 0);
        checkOutput("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] start while busy is ignored");
        applyStimulus(0, 500);
        checkOutput("busy_start_pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
